// File: rtl/fp_accum_n.sv
// fp_accum_n: streaming binary32 frame accumulator.
// Sums NUM_TERMS operands per frame and returns the total with a handshake.
module fp_accum_n #(
    parameter int XLEN      = 32,
    parameter int NUM_TERMS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_ovf
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_TERMS - 1);

    typedef enum logic {
        ACC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic [XLEN-1:0]   add_res;
    logic              add_ovf;

    logic [30:0]       mag_a, mag_b, big_mag, sml_mag;
    logic              swap, sign_big, sign_sml;
    logic [7:0]        e_big, e_sml, diff;
    logic [23:0]       m_big, m_sml;
    logic [24:0]       sum;
    logic [4:0]        lz;
    logic              lz_found;
    logic [9:0]        exp_adj;
    logic [22:0]       mant;
    logic              inf_a, inf_b;

    // Single-cycle truncating float add of acc_q and in_data (denormals flushed).
    always_comb begin
        mag_a    = (acc_q[30:23] == 8'd0) ? 31'd0 : acc_q[30:0];
        mag_b    = (in_data[30:23] == 8'd0) ? 31'd0 : in_data[30:0];
        swap     = mag_b > mag_a;
        big_mag  = swap ? mag_b : mag_a;
        sml_mag  = swap ? mag_a : mag_b;
        sign_big = swap ? in_data[31] : acc_q[31];
        sign_sml = swap ? acc_q[31] : in_data[31];
        e_big    = big_mag[30:23];
        e_sml    = sml_mag[30:23];
        diff     = e_big - e_sml;
        m_big    = {|e_big, big_mag[22:0]};
        m_sml    = (diff >= 8'd25) ? 24'd0 : ({|e_sml, sml_mag[22:0]} >> diff);
        sum      = (sign_big == sign_sml) ? ({1'b0, m_big} + {1'b0, m_sml})
                                          : ({1'b0, m_big} - {1'b0, m_sml});
        lz       = 5'd0;
        lz_found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!lz_found) begin
                if (sum[i]) lz_found = 1'b1;
                else        lz = lz + 5'd1;
            end
        end
        exp_adj  = 10'd0;
        mant     = 23'd0;
        add_res  = '0;
        add_ovf  = 1'b0;
        inf_a    = acc_q[30:23] == 8'hFF;
        inf_b    = in_data[30:23] == 8'hFF;
        if (inf_a || inf_b) begin
            // An infinity already in the sum is sticky; opposite infinities give +inf.
            if (inf_a && inf_b && (acc_q[31] != in_data[31]))
                add_res = 32'h7F80_0000;
            else if (inf_a)
                add_res = {acc_q[31], 8'hFF, 23'd0};
            else
                add_res = {in_data[31], 8'hFF, 23'd0};
        end else if (sum == 25'd0) begin
            add_res = 32'h0000_0000;
        end else begin
            if (sum[24]) begin
                exp_adj = {2'b00, e_big} + 10'd1;
                mant    = sum[23:1];
            end else begin
                exp_adj = {2'b00, e_big} - {5'd0, lz};
                mant    = sum[22:0] << lz;
            end
            if (exp_adj[9] || (exp_adj == 10'd0)) begin
                add_res = {sign_big, 31'd0};
            end else if (exp_adj >= 10'd255) begin
                add_res = {sign_big, 8'hFF, 23'd0};
                add_ovf = 1'b1;
            end else begin
                add_res = {sign_big, exp_adj[7:0], mant};
            end
        end
    end

    // Frame control: accumulate NUM_TERMS operands, then hold the result.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        unique case (state_q)
            ACC: begin
                if (in_valid && in_ready_q) begin
                    acc_d = add_res;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = ACC;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State and registered outputs; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fp_accum_n.sv
// tb_fp_accum_n: directed frames checked through an expected-result queue.
// A monitor pops and compares on every output handshake.
module tb_fp_accum_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    localparam logic [31:0] ONE = 32'h3F80_0000;

    fp_accum_n #(.XLEN(32), .NUM_TERMS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted result against the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [32:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h ovf %b expected none",
                         out_data, out_ovf);
            end else begin
                e = exp_q.pop_front();
                chk("result_data", out_data, e[31:0]);
                chk("result_ovf", {31'd0, out_ovf}, {31'd0, e[32]});
            end
        end
    end

    // Present one operand until it is accepted (bounded).
    task automatic send(input logic [31:0] d);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [31:0] e, input logic o);
        exp_q.push_back({o, e});
        send(a);
        send(b);
        send(c);
        send(d);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got in_ready %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] pat;
        logic [31:0] held;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        @(posedge clk);
        #1;

        frame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h41200000, 1'b0);
        frame(32'h40A00000, 32'hC0A00000, 32'h0, 32'h0, 32'h00000000, 1'b0);
        frame(32'hC0400000, 32'h3F800000, 32'h0, 32'h0, 32'hC0000000, 1'b0);
        frame(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h0,
              32'h7F800000, 1'b1);
        frame(32'h00000001, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 1'b0);

        // Backpressure: result held for 3 cycles, input pulses rejected.
        wait_idle();
        out_ready = 1'b0;
        frame(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h41200000, 1'b0);
        held = 32'h41200000;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h42C80000;
            @(negedge clk);
            chk("bp_out_data", out_data, held);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        frame(ONE, ONE, ONE, 32'h40000000, 32'h40A00000, 1'b0);

        // Gapped input: 1,0,0,1,1,0,1 carrying four 1.0 operands.
        wait_idle();
        pat = 7'b1011001;
        exp_q.push_back({1'b0, 32'h40800000});
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_data  = ONE;
            @(posedge clk);
            #1;
            if (i == 4)
                chk("gap_early_valid", {31'd0, out_valid}, 32'd0);
        end
        in_valid = 1'b0;
        chk("gap_latency", {31'd0, out_valid}, 32'd1);

        // Reset mid-frame discards the partial sum.
        wait_idle();
        send(ONE);
        send(ONE);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        frame(ONE, ONE, ONE, ONE, 32'h40800000, 1'b0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
